// File: rtl/db_agg_pkg.sv
// Shared types and constants for the double-buffer read address generator.
package db_agg_pkg;

  localparam int NUM_DIMS = 6;
  localparam int ADDR_W   = 16;
  localparam int RANGE_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Tile configuration captured at start; dim 0 occupies the low slice.
  typedef struct packed {
    logic [NUM_DIMS-1:0][ADDR_W-1:0]  stride;
    logic [NUM_DIMS-1:0][RANGE_W-1:0] range;
    logic [ADDR_W-1:0]                starting_addr;
    logic [RANGE_W-1:0]               iter_cnt;
    logic [3:0]                       dimensionality;
  } cfg_t;

  // Requests for more dimensions than exist collapse to the full set.
  function automatic logic [3:0] clamp_dims(input logic [3:0] d);
    return (d > 4'(NUM_DIMS)) ? 4'(NUM_DIMS) : d;
  endfunction

endpackage

// File: rtl/addr_dim_counter.sv
// One odometer digit: loop counter plus its running stride offset.
module addr_dim_counter import db_agg_pkg::*; (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic               inc,
  input  logic [RANGE_W-1:0] range,
  input  logic [ADDR_W-1:0]  stride,
  output logic               wrap,
  output logic [ADDR_W-1:0]  offset_next
);

  logic [RANGE_W-1:0] cnt;
  logic [RANGE_W-1:0] cnt_next;
  logic [RANGE_W-1:0] last;
  logic [ADDR_W-1:0]  offset;

  // A zero range behaves as a single-iteration loop, so it always wraps.
  always_comb begin
    last = (range == '0) ? '0 : range - RANGE_W'(1);
    wrap = (cnt == last);
  end

  // Offset tracks cnt*stride by accumulation, avoiding a multiplier.
  always_comb begin
    cnt_next    = cnt;
    offset_next = offset;
    if (clear) begin
      cnt_next    = '0;
      offset_next = '0;
    end else if (inc) begin
      if (wrap) begin
        cnt_next    = '0;
        offset_next = '0;
      end else begin
        cnt_next    = cnt + RANGE_W'(1);
        offset_next = offset + stride;
      end
    end
  end

  // Counter state, frozen whenever the global enable is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      offset <= '0;
    end else if (enable) begin
      cnt    <= cnt_next;
      offset <= offset_next;
    end
  end

endmodule

// File: rtl/db_read_addr_gen.sv
// Nested-loop read address generator feeding the double-buffer read port.
module db_read_addr_gen import db_agg_pkg::*; (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clk_en,
  input  logic                              flush,
  input  logic                              start,
  input  logic                              step,
  input  logic [3:0]                        dimensionality,
  input  logic [ADDR_W-1:0]                 starting_addr,
  input  logic [NUM_DIMS*ADDR_W-1:0]        stride,
  input  logic [NUM_DIMS*RANGE_W-1:0]       range,
  input  logic [RANGE_W-1:0]                iter_cnt,
  output logic [ADDR_W-1:0]                 addr_out,
  output logic                              addr_valid,
  output logic                              busy,
  output logic                              done
);

  state_t                          state;
  state_t                          state_next;
  cfg_t                            cfg;
  logic [RANGE_W-1:0]              issued;
  logic                            accept_start;
  logic                            step_run;
  logic                            last_step;
  logic                            advance;
  logic                            clear;
  logic                            carry;
  logic [NUM_DIMS-1:0]             inc;
  logic [NUM_DIMS-1:0]             wrap;
  logic [NUM_DIMS-1:0][ADDR_W-1:0] offset_next;
  logic [ADDR_W-1:0]               addr_sum;

  // Handshake qualifiers; flush overrides a coincident start.
  always_comb begin
    accept_start = (state == IDLE) && start && !flush;
    step_run     = (state == RUN) && step;
    last_step    = ((issued + RANGE_W'(1)) == cfg.iter_cnt);
    advance      = step_run && !last_step;
    clear        = flush || accept_start;
  end

  // Ripple the odometer carry through active dimensions only.
  always_comb begin
    inc   = '0;
    carry = advance;
    for (int k = 0; k < NUM_DIMS; k++) begin
      inc[k] = carry && (4'(k) < cfg.dimensionality);
      carry  = inc[k] && wrap[k];
    end
  end

  for (genvar k = 0; k < NUM_DIMS; k++) begin : g_dim
    addr_dim_counter u_cnt (
      .clk         (clk),
      .reset       (reset),
      .enable      (clk_en),
      .clear       (clear),
      .inc         (inc[k]),
      .range       (cfg.range[k]),
      .stride      (cfg.stride[k]),
      .wrap        (wrap[k]),
      .offset_next (offset_next[k])
    );
  end

  // Next address from the post-advance offsets; wraps modulo 2^ADDR_W.
  always_comb begin
    addr_sum = cfg.starting_addr;
    for (int k = 0; k < NUM_DIMS; k++) begin
      addr_sum = addr_sum + offset_next[k];
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (iter_cnt == '0) ? DONE : RUN;
      RUN:     if (step && last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
    addr_valid = (state == RUN);
    busy       = (state != IDLE);
    done       = (state == DONE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset)       state <= IDLE;
    else if (clk_en) state <= state_next;
  end

  // Configuration snapshot taken only when a run is armed.
  always_ff @(posedge clk) begin
    if (clk_en && accept_start) begin
      cfg.stride         <= stride;
      cfg.range          <= range;
      cfg.starting_addr  <= starting_addr;
      cfg.iter_cnt       <= iter_cnt;
      cfg.dimensionality <= clamp_dims(dimensionality);
    end
  end

  // Issued count and registered address output.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_out <= '0;
      issued   <= '0;
    end else if (clk_en) begin
      if (flush) begin
        addr_out <= '0;
        issued   <= '0;
      end else if (accept_start) begin
        addr_out <= starting_addr;
        issued   <= '0;
      end else if (step_run) begin
        issued <= issued + RANGE_W'(1);
        if (!last_step) addr_out <= addr_sum;
      end
    end
  end

endmodule

// File: tb/tb_db_read_addr_gen.sv
// Directed bench for the read address generator.
module tb_db_read_addr_gen;
  import db_agg_pkg::*;

  logic                        clk;
  logic                        reset;
  logic                        clk_en;
  logic                        flush;
  logic                        start;
  logic                        step;
  logic [3:0]                  dimensionality;
  logic [ADDR_W-1:0]           starting_addr;
  logic [NUM_DIMS*ADDR_W-1:0]  stride;
  logic [NUM_DIMS*RANGE_W-1:0] range;
  logic [RANGE_W-1:0]          iter_cnt;
  logic [ADDR_W-1:0]           addr_out;
  logic                        addr_valid;
  logic                        busy;
  logic                        done;

  int n_cmp;
  int n_err;

  db_read_addr_gen dut (
    .clk            (clk),
    .reset          (reset),
    .clk_en         (clk_en),
    .flush          (flush),
    .start          (start),
    .step           (step),
    .dimensionality (dimensionality),
    .starting_addr  (starting_addr),
    .stride         (stride),
    .range          (range),
    .iter_cnt       (iter_cnt),
    .addr_out       (addr_out),
    .addr_valid     (addr_valid),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [15:0] sa, input logic [15:0] s0, input logic [15:0] s1,
                         input logic [15:0] s2, input logic [31:0] r0, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [3:0] d, input logic [31:0] it);
    stride = '0;
    range  = '0;
    stride[15:0]  = s0;
    stride[31:16] = s1;
    stride[47:32] = s2;
    range[31:0]   = r0;
    range[63:32]  = r1;
    range[95:64]  = r2;
    starting_addr  = sa;
    dimensionality = d;
    iter_cnt       = it;
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({addr_valid, busy, done, addr_out} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_state: got v=%0b b=%0b d=%0b a=%0d expected all 0",
               addr_valid, busy, done, addr_out);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_config_a();
    set_cfg(16'd0, 16'd1, 16'd3, 16'd9, 32'd3, 32'd3, 32'd3, 4'd3, 32'd27);
    arm();
    starting_addr = 16'h1234;
    step = 1'b1;
    for (int i = 0; i < 27; i++) begin
      n_cmp++;
      if ({addr_valid, done, addr_out} !== {1'b1, 1'b0, 16'(i)}) begin
        n_err++;
        $display("FAIL a_seq[%0d]: got v=%0b d=%0b a=%0d expected v=1 d=0 a=%0d",
                 i, addr_valid, done, addr_out, i);
      end
      tick();
    end
    n_cmp++;
    if ({done, addr_valid, busy} !== 3'b101) begin
      n_err++;
      $display("FAIL a_done: got d=%0b v=%0b b=%0b expected d=1 v=0 b=1", done, addr_valid, busy);
    end
    step = 1'b0;
    tick();
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL a_idle: got d=%0b b=%0b expected 0 0", done, busy);
    end
  endtask

  task automatic test_config_b();
    logic [15:0] exp_b [5];
    exp_b = '{16'd100, 16'd101, 16'd104, 16'd105, 16'd100};
    set_cfg(16'd100, 16'd1, 16'd4, 16'd50, 32'd2, 32'd2, 32'd7, 4'd2, 32'd5);
    arm();
    step = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({addr_valid, addr_out} !== {1'b1, exp_b[i]}) begin
        n_err++;
        $display("FAIL b_seq[%0d]: got v=%0b a=%0d expected v=1 a=%0d", i, addr_valid, addr_out, exp_b[i]);
      end
      tick();
    end
    step = 1'b0;
    n_cmp++;
    if ({done, addr_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL b_done: got d=%0b v=%0b expected d=1 v=0", done, addr_valid);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [15:0] exp_b [5];
    bit          en_t  [12];
    bit          st_t  [12];
    int          consumed;
    logic [15:0] prev;
    exp_b = '{16'd100, 16'd101, 16'd104, 16'd105, 16'd100};
    en_t  = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    st_t  = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 1, 1};
    set_cfg(16'd100, 16'd1, 16'd4, 16'd0, 32'd2, 32'd2, 32'd0, 4'd2, 32'd5);
    clk_en = 1'b0;
    start  = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL stall_start_gated: got busy=%0b expected 0", busy);
    end
    clk_en = 1'b1;
    tick();
    start = 1'b0;
    consumed = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      clk_en = en_t[cyc % 12];
      step   = st_t[cyc % 12];
      prev   = addr_out;
      if (clk_en && step && addr_valid) begin
        n_cmp++;
        if (consumed >= 5 || addr_out !== exp_b[consumed]) begin
          n_err++;
          $display("FAIL stall_seq[%0d]: got a=%0d expected a=%0d", consumed, addr_out,
                   (consumed < 5) ? exp_b[consumed] : 16'hffff);
        end
        consumed++;
      end
      tick();
      if (!clk_en) begin
        n_cmp++;
        if (addr_out !== prev) begin
          n_err++;
          $display("FAIL stall_frozen: got a=%0d expected a=%0d", addr_out, prev);
        end
      end
      if (done) break;
    end
    clk_en = 1'b1;
    step   = 1'b0;
    n_cmp++;
    if (consumed !== 5 || done !== 1'b1) begin
      n_err++;
      $display("FAIL stall_count: got %0d steps done=%0b expected 5 steps done=1", consumed, done);
    end
    tick();
  endtask

  task automatic test_flush();
    set_cfg(16'd0, 16'd1, 16'd3, 16'd9, 32'd3, 32'd3, 32'd3, 4'd3, 32'd27);
    arm();
    step = 1'b1;
    tick();
    tick();
    step = 1'b0;
    n_cmp++;
    if (addr_out !== 16'd2) begin
      n_err++;
      $display("FAIL flush_pre: got a=%0d expected 2", addr_out);
    end
    flush = 1'b1;
    start = 1'b1;
    tick();
    flush = 1'b0;
    start = 1'b0;
    n_cmp++;
    if ({addr_valid, busy, done, addr_out} !== 19'd0) begin
      n_err++;
      $display("FAIL flush_state: got v=%0b b=%0b d=%0b a=%0d expected all 0",
               addr_valid, busy, done, addr_out);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL flush_no_done: got d=%0b expected 0", done);
      end
    end
    arm();
    n_cmp++;
    if ({addr_valid, addr_out} !== {1'b1, 16'd0}) begin
      n_err++;
      $display("FAIL flush_replay0: got v=%0b a=%0d expected v=1 a=0", addr_valid, addr_out);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    n_cmp++;
    if (addr_out !== 16'd1) begin
      n_err++;
      $display("FAIL flush_replay1: got a=%0d expected 1", addr_out);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_iter_zero();
    set_cfg(16'd7, 16'd1, 16'd1, 16'd1, 32'd3, 32'd3, 32'd3, 4'd3, 32'd0);
    arm();
    n_cmp++;
    if ({done, addr_valid, busy} !== 3'b101) begin
      n_err++;
      $display("FAIL iter0_done: got d=%0b v=%0b b=%0b expected d=1 v=0 b=1", done, addr_valid, busy);
    end
    tick();
    n_cmp++;
    if ({done, addr_valid, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL iter0_idle: got d=%0b v=%0b b=%0b expected 0 0 0", done, addr_valid, busy);
    end
  endtask

  task automatic test_dim_zero();
    set_cfg(16'd55, 16'd5, 16'd6, 16'd7, 32'd3, 32'd3, 32'd3, 4'd0, 32'd3);
    arm();
    step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({addr_valid, addr_out} !== {1'b1, 16'd55}) begin
        n_err++;
        $display("FAIL dim0_seq[%0d]: got v=%0b a=%0d expected v=1 a=55", i, addr_valid, addr_out);
      end
      tick();
    end
    step = 1'b0;
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL dim0_done: got d=%0b expected 1", done);
    end
    tick();
  endtask

  task automatic test_range_zero();
    logic [15:0] exp_r [6];
    exp_r = '{16'd10, 16'd12, 16'd14, 16'd10, 16'd12, 16'd14};
    set_cfg(16'd10, 16'd2, 16'd7, 16'd0, 32'd3, 32'd0, 32'd0, 4'd2, 32'd6);
    arm();
    step = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (addr_out !== exp_r[i]) begin
        n_err++;
        $display("FAIL range0_seq[%0d]: got a=%0d expected a=%0d", i, addr_out, exp_r[i]);
      end
      tick();
    end
    step = 1'b0;
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL range0_done: got d=%0b expected 1", done);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    set_cfg(16'd0, 16'd1, 16'd3, 16'd9, 32'd3, 32'd3, 32'd3, 4'd3, 32'd27);
    arm();
    step = 1'b1;
    repeat (10) tick();
    step = 1'b0;
    n_cmp++;
    if (addr_out !== 16'd10) begin
      n_err++;
      $display("FAIL rst_mid_pre: got a=%0d expected 10", addr_out);
    end
    reset = 1'b1;
    start = 1'b1;
    tick();
    n_cmp++;
    if ({addr_valid, busy, done, addr_out} !== 19'd0) begin
      n_err++;
      $display("FAIL rst_mid_state: got v=%0b b=%0b d=%0b a=%0d expected all 0",
               addr_valid, busy, done, addr_out);
    end
    reset = 1'b0;
    start = 1'b0;
    tick();
    n_cmp++;
    if ({busy, addr_out} !== 17'd0) begin
      n_err++;
      $display("FAIL rst_start_ignored: got b=%0b a=%0d expected b=0 a=0", busy, addr_out);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    reset  = 1'b1;
    clk_en = 1'b1;
    flush  = 1'b0;
    start  = 1'b0;
    step   = 1'b0;
    set_cfg(16'd0, 16'd0, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0, 4'd0, 32'd0);
    test_reset();
    test_config_a();
    test_config_b();
    test_stall();
    test_flush();
    test_iter_zero();
    test_dim_zero();
    test_range_zero();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
